demultiplex: RTL and testbench

Registered tag-routing demultiplexer that consumes the `{address, data}` stream produced by the priority multiplexer stage. It strips the address tag and delivers each payload to one of `N` downstream masters. Each destination has its own one-entry holding register, so a stalled destination blocks only traffic addressed to it. Sits directly downstream of the multiplexer, e.g. fanning a shared arbitrated bus back out to per-channel consumers.

---
 rtl/demultiplex.sv | 77 +++++++
 tb/tb_demultiplex.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/demultiplex.sv
// demultiplex: routes tagged {addr, payload} words to N registered output slots.
// Ports: clk/rst, s_stb/s_dat/s_rdy (tagged input), m_stb/m_dat/m_rdy (per slot), err.
module demultiplex #(
  parameter int W = 8,
  parameter int N = 2,
  localparam int A = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_stb,
  input  logic [A+W-1:0] s_dat,
  output logic           s_rdy,
  output logic [N-1:0]   m_stb,
  output logic [N*W-1:0] m_dat,
  input  logic [N-1:0]   m_rdy,
  output logic           err
);

  logic [A-1:0]   adr;
  logic [W-1:0]   pay;
  int unsigned    adr_u;
  logic           adr_ok;
  logic           slot_free;
  logic           acc;

  logic [N-1:0]   stb_q, stb_d;
  logic [N*W-1:0] dat_q, dat_d;
  logic           err_q, err_d;

  assign adr    = s_dat[A+W-1:W];
  assign pay    = s_dat[W-1:0];
  assign adr_u  = 32'(adr);
  assign adr_ok = adr_u < 32'(N);

  // Selected slot can take a word if empty or draining this cycle.
  always_comb begin
    slot_free = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (adr_u == 32'(k)) begin
        slot_free = ~stb_q[k] | m_rdy[k];
      end
    end
  end

  // Out-of-range tags are always taken so they can be discarded.
  assign s_rdy = ~adr_ok | slot_free;
  assign acc   = s_stb & s_rdy;

  always_comb begin
    stb_d = stb_q & ~m_rdy;
    dat_d = dat_q;
    err_d = acc & ~adr_ok;
    for (int k = 0; k < N; k++) begin
      if (acc && adr_ok && adr_u == 32'(k)) begin
        stb_d[k]         = 1'b1;
        dat_d[k*W +: W]  = pay;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stb_q <= '0;
      dat_q <= '0;
      err_q <= 1'b0;
    end else begin
      stb_q <= stb_d;
      dat_q <= dat_d;
      err_q <= err_d;
    end
  end

  assign m_stb = stb_q;
  assign m_dat = dat_q;
  assign err   = err_q;

endmodule

// File: tb/tb_demultiplex.sv
// tb_demultiplex: directed stimulus with a slot-level reference model.
// Checks every cycle against the model plus hand-computed literals.
module tb_demultiplex;

  localparam int W = 8;
  localparam int N = 3;
  localparam int A = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_stb;
  logic [A+W-1:0] s_dat;
  logic           s_rdy;
  logic [N-1:0]   m_stb;
  logic [N*W-1:0] m_dat;
  logic [N-1:0]   m_rdy;
  logic           err;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference: each destination is a one-word mailbox.
  bit       mv [N];
  bit [7:0] md [N];
  bit       merr;

  demultiplex #(.W(W), .N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .s_stb (s_stb),
    .s_dat (s_dat),
    .s_rdy (s_rdy),
    .m_stb (m_stb),
    .m_dat (m_dat),
    .m_rdy (m_rdy),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit mdl_rdy();
    int a;
    a = int'(s_dat[A+W-1:W]);
    if (a >= N) return 1'b1;
    return !mv[a] || m_rdy[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        mv[k] = 1'b0;
        md[k] = 8'h00;
      end
      merr = 1'b0;
    end else begin
      int  a;
      bit  take;
      a    = int'(s_dat[A+W-1:W]);
      take = s_stb && mdl_rdy();
      for (int k = 0; k < N; k++)
        if (mv[k] && m_rdy[k]) mv[k] = 1'b0;
      merr = take && (a >= N);
      if (take && a < N) begin
        mv[a] = 1'b1;
        md[a] = s_dat[W-1:0];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [N-1:0]   es;
      logic [N*W-1:0] ed;
      for (int k = 0; k < N; k++) begin
        es[k]         = mv[k];
        ed[k*W +: W]  = md[k];
      end
      chk("model_m_stb", 32'(m_stb), 32'(es));
      chk("model_m_dat", 32'(m_dat), 32'(ed));
      chk("model_err", 32'(err), 32'(merr));
      chk("model_s_rdy", 32'(s_rdy), 32'(mdl_rdy()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    s_stb = 1'b0;
    s_dat = '0;
    m_rdy = '0;
    cyc();
    cyc();
    rst    = 1'b0;
    chk_en = 1'b1;
    neg();
    chk("rst_m_stb", 32'(m_stb), 32'h0);
    chk("rst_m_dat", 32'(m_dat), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_s_rdy", 32'(s_rdy), 32'h1);

    // single routing
    cyc();
    m_rdy = 3'b111;
    s_stb = 1'b1;
    s_dat = {2'd2, 8'hA5};
    cyc();
    s_stb = 1'b0;
    neg();
    chk("route_stb", 32'(m_stb), 32'h4);
    chk("route_dat", 32'(m_dat[23:16]), 32'hA5);
    cyc();
    neg();
    chk("route_drain", 32'(m_stb), 32'h0);

    // back-pressure on slot 1
    cyc();
    m_rdy = 3'b101;
    s_stb = 1'b1;
    s_dat = {2'd1, 8'h11};
    cyc();
    s_dat = {2'd1, 8'h22};
    for (int i = 0; i < 2; i++) begin
      neg();
      chk("bp_s_rdy", 32'(s_rdy), 32'h0);
      chk("bp_hold_stb", 32'(m_stb[1]), 32'h1);
      chk("bp_hold_dat", 32'(m_dat[15:8]), 32'h11);
      cyc();
    end
    m_rdy = 3'b111;
    neg();
    chk("bp_release_rdy", 32'(s_rdy), 32'h1);
    cyc();
    s_stb = 1'b0;
    neg();
    chk("bp_second_stb", 32'(m_stb[1]), 32'h1);
    chk("bp_second_dat", 32'(m_dat[15:8]), 32'h22);
    cyc();
    neg();
    chk("bp_empty", 32'(m_stb), 32'h0);

    // independence: slot 1 stalled, slot 0 streams
    cyc();
    m_rdy = 3'b101;
    s_stb = 1'b1;
    s_dat = {2'd1, 8'h77};
    cyc();
    s_dat = {2'd0, 8'h01};
    cyc();
    s_dat = {2'd0, 8'h02};
    neg();
    chk("ind_rdy", 32'(s_rdy), 32'h1);
    chk("ind_d1", 32'(m_dat[7:0]), 32'h01);
    chk("ind_s1", 32'(m_dat[15:8]), 32'h77);
    cyc();
    s_dat = {2'd0, 8'h03};
    neg();
    chk("ind_d2", 32'(m_dat[7:0]), 32'h02);
    chk("ind_stb2", 32'(m_stb), 32'h3);
    cyc();
    s_stb = 1'b0;
    neg();
    chk("ind_d3", 32'(m_dat[7:0]), 32'h03);
    chk("ind_s1b", 32'(m_dat[15:8]), 32'h77);
    cyc();
    neg();
    chk("ind_end", 32'(m_stb), 32'h2);

    // bad address
    cyc();
    s_stb = 1'b1;
    s_dat = {2'd3, 8'hFF};
    neg();
    chk("bad_rdy", 32'(s_rdy), 32'h1);
    cyc();
    s_stb = 1'b0;
    neg();
    chk("bad_err", 32'(err), 32'h1);
    chk("bad_stb", 32'(m_stb), 32'h2);
    cyc();
    neg();
    chk("bad_err_clr", 32'(err), 32'h0);

    // reset mid-operation
    cyc();
    m_rdy = 3'b000;
    s_stb = 1'b1;
    s_dat = {2'd0, 8'hAA};
    cyc();
    s_dat = {2'd2, 8'hBB};
    cyc();
    s_stb = 1'b0;
    neg();
    chk("pre_rst_stb", 32'(m_stb), 32'h7);
    chk("pre_rst_dat", 32'(m_dat), 32'hBB77AA);
    cyc();
    rst   = 1'b1;
    s_stb = 1'b1;
    s_dat = {2'd0, 8'hCC};
    cyc();
    rst   = 1'b0;
    s_stb = 1'b0;
    neg();
    chk("mid_rst_stb", 32'(m_stb), 32'h0);
    chk("mid_rst_dat", 32'(m_dat), 32'h0);
    m_rdy = 3'b111;
    for (int i = 0; i < 3; i++) begin
      cyc();
      neg();
      chk("post_rst_stb", 32'(m_stb), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
